// File: rtl/axi_mm_slave_mem.sv
// AXI4 memory-mapped slave backed by a word-addressed memory.
// Optional AXI_SLV_BACKPRESSURE_EN halves write throughput and delays awready/arready by one idle cycle.
module axi_mm_slave_mem #(
    parameter int ASIZE        = 29,
    parameter int DSIZE        = 256,
    parameter int LSIZE        = 9,
    parameter int IDSIZE       = 4,
    parameter int ADDR_STEP    = 64,
    parameter int MEM_AW       = 10,
    parameter int ENOUGH_BEATS = 256
) (
    input  logic               axi_aclk,
    input  logic               axi_resetn,
    input  logic [IDSIZE-1:0]  axi_awid,
    input  logic [ASIZE-1:0]   axi_awaddr,
    input  logic [LSIZE-1:0]   axi_awlen,
    input  logic               axi_awvalid,
    output logic               axi_awready,
    input  logic [DSIZE-1:0]   axi_wdata,
    input  logic [DSIZE/8-1:0] axi_wstrb,
    input  logic               axi_wlast,
    input  logic               axi_wvalid,
    output logic               axi_wready,
    output logic [IDSIZE-1:0]  axi_bid,
    output logic [1:0]         axi_bresp,
    output logic               axi_bvalid,
    input  logic               axi_bready,
    input  logic [IDSIZE-1:0]  axi_arid,
    input  logic [ASIZE-1:0]   axi_araddr,
    input  logic [LSIZE-1:0]   axi_arlen,
    input  logic               axi_arvalid,
    output logic               axi_arready,
    output logic [IDSIZE-1:0]  axi_rid,
    output logic [DSIZE-1:0]   axi_rdata,
    output logic [1:0]         axi_rresp,
    output logic               axi_rlast,
    output logic               axi_rvalid,
    input  logic               axi_rready,
    output logic [31:0]        wr_beat_cnt,
    output logic               data_enough
);

    localparam int NBYTES = DSIZE / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ASIZE-1:0] a);
        logic [ASIZE-1:0] q;
        q = a / ASIZE'(ADDR_STEP);
        return q[MEM_AW-1:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [DSIZE-1:0]  mem [0:(2**MEM_AW)-1];

    w_state_t          w_state, w_state_nx;
    r_state_t          r_state, r_state_nx;
    logic              aw_hs, w_beat, w_end, ar_hs, r_beat;
    logic              aw_en, ar_en, w_tog;

    logic [IDSIZE-1:0] bid_q, rid_q;
    logic [LSIZE-1:0]  awlen_q, arlen_q, wcnt, rcnt;
    logic [MEM_AW-1:0] widx, ridx;
    logic [1:0]        bresp_q;

`ifdef AXI_SLV_BACKPRESSURE_EN
    // Ready enables lag the IDLE state by a cycle; wready alternates starting high.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            aw_en <= 1'b1;
            ar_en <= 1'b1;
            w_tog <= 1'b1;
        end else begin
            aw_en <= (w_state == W_IDLE);
            ar_en <= (r_state == R_IDLE);
            w_tog <= (w_state == W_DATA) ? ~w_tog : 1'b1;
        end
    end
`else
    assign aw_en = 1'b1;
    assign ar_en = 1'b1;
    assign w_tog = 1'b1;
`endif

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = w_state;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        aw_hs       = 1'b0;
        w_beat      = 1'b0;
        w_end       = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi_awready = aw_en;
                aw_hs       = axi_awvalid & aw_en;
                if (aw_hs) w_state_nx = W_DATA;
            end
            W_DATA: begin
                axi_wready = w_tog;
                w_beat     = axi_wvalid & w_tog;
                // A burst ends on wlast or when awlen+1 beats have arrived, whichever first.
                w_end      = w_beat & (axi_wlast | (wcnt == awlen_q));
                if (w_end) w_state_nx = W_RESP;
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nx  = r_state;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        ar_hs       = 1'b0;
        r_beat      = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi_arready = ar_en;
                ar_hs       = axi_arvalid & ar_en;
                if (ar_hs) r_state_nx = R_DATA;
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                axi_rlast  = (rcnt == arlen_q);
                r_beat     = axi_rready;
                if (r_beat && axi_rlast) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            bid_q       <= '0;
            awlen_q     <= '0;
            widx        <= '0;
            wcnt        <= '0;
            bresp_q     <= 2'b00;
            wr_beat_cnt <= 32'd0;
            data_enough <= 1'b0;
        end else begin
            if (aw_hs) begin
                bid_q   <= axi_awid;
                awlen_q <= axi_awlen;
                widx    <= word_idx(axi_awaddr);
                wcnt    <= '0;
            end
            if (w_beat) begin
                widx        <= widx + 1'b1;
                wcnt        <= wcnt + 1'b1;
                wr_beat_cnt <= sat_inc(wr_beat_cnt);
            end
            if (w_end) bresp_q <= (axi_wlast && (wcnt == awlen_q)) ? 2'b00 : 2'b10;
            data_enough <= data_enough | (wr_beat_cnt >= 32'(ENOUGH_BEATS));
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rid_q   <= '0;
            arlen_q <= '0;
            ridx    <= '0;
            rcnt    <= '0;
        end else if (ar_hs) begin
            rid_q   <= axi_arid;
            arlen_q <= axi_arlen;
            ridx    <= word_idx(axi_araddr);
            rcnt    <= '0;
        end else if (r_beat) begin
            ridx <= ridx + 1'b1;
            rcnt <= rcnt + 1'b1;
        end
    end

    // Memory contents survive reset; byte lanes are gated by wstrb.
    always_ff @(posedge axi_aclk) begin
        if (w_beat) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (axi_wstrb[b]) mem[widx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
        end
    end

    assign axi_bid   = bid_q;
    assign axi_bresp = bresp_q;
    assign axi_rid   = rid_q;
    assign axi_rresp = 2'b00;
    assign axi_rdata = (r_state == R_DATA) ? mem[ridx] : '0;

endmodule

// File: tb/tb_axi_mm_slave_mem.sv
// Directed self-checking bench for axi_mm_slave_mem.
module tb_axi_mm_slave_mem;

    logic         axi_aclk;
    logic         axi_resetn;
    logic [3:0]   axi_awid;
    logic [28:0]  axi_awaddr;
    logic [8:0]   axi_awlen;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wlast;
    logic         axi_wvalid;
    logic         axi_wready;
    logic [3:0]   axi_bid;
    logic [1:0]   axi_bresp;
    logic         axi_bvalid;
    logic         axi_bready;
    logic [3:0]   axi_arid;
    logic [28:0]  axi_araddr;
    logic [8:0]   axi_arlen;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [3:0]   axi_rid;
    logic [255:0] axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;
    logic [31:0]  wr_beat_cnt;
    logic         data_enough;

    axi_mm_slave_mem dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .wr_beat_cnt(wr_beat_cnt), .data_enough(data_enough)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int checks = 0;
    int errors = 0;

    logic [255:0] w_data [0:15];
    logic [31:0]  w_strb;
    logic [255:0] cap_data [0:15];
    logic         cap_last [0:15];
    logic [3:0]   cap_rid;
    logic [1:0]   cap_bresp;
    logic [3:0]   cap_bid;
    int           cap_n;
    bit           stall_moved, to_flag, wready_after, rvalid_after;

    task automatic do_write(input logic [28:0] addr, input logic [8:0] len, input logic [3:0] id,
                            input int n, input int last_at);
        int g;
        to_flag = 0;
        axi_awaddr = addr; axi_awlen = len; axi_awid = id; axi_awvalid = 1'b1;
        g = 0;
        @(negedge axi_aclk);
        while (!axi_awready && g < 50) begin @(negedge axi_aclk); g++; end
        if (g >= 50) to_flag = 1;
        @(posedge axi_aclk); #1;
        axi_awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            axi_wdata = w_data[i]; axi_wstrb = w_strb; axi_wlast = (i == last_at); axi_wvalid = 1'b1;
            g = 0;
            @(negedge axi_aclk);
            while (!axi_wready && g < 50) begin @(negedge axi_aclk); g++; end
            if (g >= 50) to_flag = 1;
            @(posedge axi_aclk); #1;
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        @(negedge axi_aclk);
        wready_after = axi_wready;
        axi_bready = 1'b1;
        g = 0;
        while (!axi_bvalid && g < 50) begin @(negedge axi_aclk); g++; end
        if (g >= 50) to_flag = 1;
        cap_bresp = axi_bresp; cap_bid = axi_bid;
        @(posedge axi_aclk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [28:0] addr, input logic [8:0] len, input logic [3:0] id,
                           input bit toggle);
        int g;
        bit phase, held_v;
        logic [255:0] held;
        to_flag = 0; stall_moved = 0; cap_n = 0; held_v = 0; held = '0;
        phase = toggle ? 1'b0 : 1'b1;
        axi_araddr = addr; axi_arlen = len; axi_arid = id; axi_arvalid = 1'b1;
        g = 0;
        @(negedge axi_aclk);
        while (!axi_arready && g < 50) begin @(negedge axi_aclk); g++; end
        if (g >= 50) to_flag = 1;
        @(posedge axi_aclk); #1;
        axi_arvalid = 1'b0;
        g = 0;
        while (cap_n <= int'(len) && cap_n < 16 && g < 100) begin
            axi_rready = phase;
            @(negedge axi_aclk);
            if (axi_rvalid) begin
                if (held_v && axi_rdata !== held) stall_moved = 1;
                if (axi_rready) begin
                    held_v = 0;
                    cap_data[cap_n] = axi_rdata;
                    cap_last[cap_n] = axi_rlast;
                    cap_rid = axi_rid;
                    cap_n++;
                end else begin
                    held = axi_rdata; held_v = 1;
                end
            end
            @(posedge axi_aclk); #1;
            if (toggle) phase = ~phase;
            g++;
        end
        if (cap_n <= int'(len)) to_flag = 1;
        axi_rready = 1'b0;
        @(negedge axi_aclk);
        rvalid_after = axi_rvalid;
        @(posedge axi_aclk); #1;
    endtask

    task automatic test_reset();
        axi_resetn = 1'b0;
        repeat (5) @(posedge axi_aclk);
        #1;
        checks++; if (axi_awready !== 1'b1) begin errors++; $display("FAIL reset_awready got %b want 1", axi_awready); end
        checks++; if (axi_arready !== 1'b1) begin errors++; $display("FAIL reset_arready got %b want 1", axi_arready); end
        checks++; if (axi_wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b want 0", axi_wready); end
        checks++; if (axi_bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b want 0", axi_bvalid); end
        checks++; if (axi_rvalid !== 1'b0 || axi_rlast !== 1'b0) begin errors++; $display("FAIL reset_rvalid_rlast got %b%b want 00", axi_rvalid, axi_rlast); end
        checks++; if (axi_bresp !== 2'b00 || axi_bid !== 4'd0 || axi_rid !== 4'd0) begin errors++; $display("FAIL reset_ids_resp got bresp=%b bid=%0d rid=%0d want 0", axi_bresp, axi_bid, axi_rid); end
        checks++; if (axi_rdata !== 256'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", axi_rdata); end
        checks++; if (wr_beat_cnt !== 32'd0 || data_enough !== 1'b0) begin errors++; $display("FAIL reset_counter got cnt=%0d enough=%b want 0/0", wr_beat_cnt, data_enough); end
        axi_resetn = 1'b1;
        @(posedge axi_aclk); #1;
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 4; i++) w_data[i] = 256'(i);
        w_strb = 32'hFFFF_FFFF;
        do_write(29'd0, 9'd3, 4'd5, 4, 3);
        checks++; if (to_flag) begin errors++; $display("FAIL wr_burst_timeout got timeout want handshakes"); end
        checks++; if (cap_bresp !== 2'b00) begin errors++; $display("FAIL wr_burst_bresp got %b want 00", cap_bresp); end
        checks++; if (cap_bid !== 4'd5) begin errors++; $display("FAIL wr_burst_bid got %0d want 5", cap_bid); end
        checks++; if (wr_beat_cnt !== 32'd4) begin errors++; $display("FAIL wr_burst_cnt got %0d want 4", wr_beat_cnt); end
        checks++; if (axi_bvalid !== 1'b0) begin errors++; $display("FAIL wr_burst_bvalid_drop got %b want 0", axi_bvalid); end
    endtask

    task automatic test_read_burst();
        do_read(29'd0, 9'd3, 4'd9, 1'b0);
        checks++; if (to_flag) begin errors++; $display("FAIL rd_burst_timeout got %0d beats want 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== 256'(i)) begin errors++; $display("FAIL rd_burst_data%0d got %h want %0d", i, cap_data[i], i); end
            checks++; if (cap_last[i] !== (i == 3)) begin errors++; $display("FAIL rd_burst_rlast%0d got %b want %b", i, cap_last[i], (i == 3)); end
        end
        checks++; if (cap_rid !== 4'd9) begin errors++; $display("FAIL rd_burst_rid got %0d want 9", cap_rid); end
        checks++; if (rvalid_after !== 1'b0) begin errors++; $display("FAIL rd_burst_rvalid_drop got %b want 0", rvalid_after); end
    endtask

    task automatic test_read_stall();
        do_read(29'd0, 9'd3, 4'd3, 1'b1);
        checks++; if (to_flag) begin errors++; $display("FAIL rd_stall_timeout got %0d beats want 4", cap_n); end
        checks++; if (stall_moved) begin errors++; $display("FAIL rd_stall_stable got rdata changed while stalled want stable"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== 256'(i)) begin errors++; $display("FAIL rd_stall_data%0d got %h want %0d", i, cap_data[i], i); end
        end
        checks++; if (cap_last[3] !== 1'b1 || cap_last[2] !== 1'b0) begin errors++; $display("FAIL rd_stall_rlast got %b%b want 10", cap_last[3], cap_last[2]); end
    endtask

    task automatic test_early_wlast();
        for (int i = 0; i < 3; i++) w_data[i] = 256'(32'hA0 + i);
        w_strb = 32'hFFFF_FFFF;
        do_write(29'd256, 9'd3, 4'd7, 3, 2);
        checks++; if (to_flag) begin errors++; $display("FAIL early_timeout got timeout want handshakes"); end
        checks++; if (wready_after !== 1'b0) begin errors++; $display("FAIL early_wready_drop got %b want 0", wready_after); end
        checks++; if (cap_bresp !== 2'b10) begin errors++; $display("FAIL early_bresp got %b want 10", cap_bresp); end
        checks++; if (cap_bid !== 4'd7) begin errors++; $display("FAIL early_bid got %0d want 7", cap_bid); end
        checks++; if (wr_beat_cnt !== 32'd7) begin errors++; $display("FAIL early_cnt got %0d want 7", wr_beat_cnt); end
        do_read(29'd256, 9'd2, 4'd1, 1'b0);
        checks++; if (cap_data[2] !== 256'h A2) begin errors++; $display("FAIL early_readback got %h want a2", cap_data[2]); end
    endtask

    task automatic test_strobe();
        w_data[0] = {256{1'b1}};
        w_strb = 32'hFFFF_FFFF;
        do_write(29'd640, 9'd0, 4'd2, 1, 0);
        checks++; if (cap_bresp !== 2'b00 || to_flag) begin errors++; $display("FAIL strobe_single_bresp got %b want 00", cap_bresp); end
        w_data[0] = 256'd0;
        w_strb = 32'h0000_FFFF;
        do_write(29'd640, 9'd0, 4'd2, 1, 0);
        do_read(29'd640, 9'd0, 4'd4, 1'b0);
        checks++; if (cap_data[0] !== {{128{1'b1}}, 128'd0}) begin errors++; $display("FAIL strobe_data got %h want upper half ones", cap_data[0]); end
        checks++; if (cap_last[0] !== 1'b1) begin errors++; $display("FAIL strobe_rlast got %b want 1", cap_last[0]); end
        checks++; if (wr_beat_cnt !== 32'd9) begin errors++; $display("FAIL strobe_cnt got %0d want 9", wr_beat_cnt); end
    endtask

    task automatic test_data_enough();
        int tos;
        tos = 0;
        axi_resetn = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
        @(posedge axi_aclk); #1;
        checks++; if (wr_beat_cnt !== 32'd0) begin errors++; $display("FAIL enough_reset_cnt got %0d want 0", wr_beat_cnt); end
        w_strb = 32'hFFFF_FFFF;
        for (int k = 0; k < 255; k++) begin
            w_data[0] = 256'(k + 100);
            do_write(29'(k * 64), 9'd0, 4'(k), 1, 0);
            if (to_flag) tos++;
        end
        checks++; if (tos != 0) begin errors++; $display("FAIL enough_timeouts got %0d want 0", tos); end
        checks++; if (data_enough !== 1'b0) begin errors++; $display("FAIL enough_early got %b want 0 at 255", data_enough); end
        checks++; if (wr_beat_cnt !== 32'd255) begin errors++; $display("FAIL enough_cnt255 got %0d want 255", wr_beat_cnt); end
        w_data[0] = 256'd355;
        do_write(29'(255 * 64), 9'd0, 4'd15, 1, 0);
        checks++; if (data_enough !== 1'b1) begin errors++; $display("FAIL enough_rise got %b want 1", data_enough); end
        checks++; if (wr_beat_cnt !== 32'd256) begin errors++; $display("FAIL enough_cnt256 got %0d want 256", wr_beat_cnt); end
        do_read(29'(255 * 64), 9'd0, 4'd6, 1'b0);
        checks++; if (cap_data[0] !== 256'd355 || to_flag) begin errors++; $display("FAIL enough_readback got %h want 163", cap_data[0]); end
        do_read(29'(3 * 64), 9'd0, 4'd6, 1'b0);
        checks++; if (cap_data[0] !== 256'd103) begin errors++; $display("FAIL enough_readback3 got %h want 67", cap_data[0]); end
        checks++; if (data_enough !== 1'b1) begin errors++; $display("FAIL enough_sticky got %b want 1", data_enough); end
    endtask

    initial begin
        axi_resetn = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0;
        axi_rready = 1'b0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_stall();
        test_early_wlast();
        test_strobe();
        test_data_enough();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
